// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and rotating-priority pick function for fifo_wr_arbiter
package fifo_arb_pkg;

    localparam int STAT_W  = 32;
    localparam int MAX_REQ = 16;
    localparam int PICK_W  = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic              found;
        logic [PICK_W-1:0] idx;
    } pick_t;

    // First set bit of req[n-1:0], searching cyclically from last_idx+1.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                      input logic [PICK_W-1:0]  last_idx,
                                      input int unsigned        n);
        pick_t       p;
        int unsigned j;
        p = '0;
        for (int unsigned k = 1; k <= MAX_REQ; k++) begin
            j = (32'(last_idx) + k) % n;
            if (k <= n && !p.found && req[j[PICK_W-1:0]]) begin
                p.found = 1'b1;
                p.idx   = j[PICK_W-1:0];
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - combinational rotating-priority encoder
module rr_priority_picker
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int IW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      last_idx_i,
    output logic [IW-1:0]      pick_idx_o,
    output logic               found_o
);

    logic [MAX_REQ-1:0] req_ext;
    logic [PICK_W-1:0]  last_ext;
    pick_t              pick;

    always_comb begin
        req_ext                 = '0;
        req_ext[NUM_REQ-1:0]    = req_i;
        last_ext                = '0;
        last_ext[IW-1:0]        = last_idx_i;
        pick                    = rr_pick(req_ext, last_ext, NUM_REQ);
        pick_idx_o              = IW'(pick.idx);
        found_o                 = pick.found;
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter onto the sync_fifo write port; FIFO_WR_ARB_STATS_EN adds counters
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    input  logic                          fifo_full,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0]             stall_cnt,
    output logic [NUM_REQ*STAT_W-1:0]     beat_total
`endif
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [IW-1:0]      LAST_REQ  = IW'(NUM_REQ - 1);
    localparam logic [BW-1:0]      BURST_LEN = BW'(MAX_BURST);
    localparam logic [NUM_REQ-1:0] ONE_HOT0  = NUM_REQ'(1);

    arb_state_e         state_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [IW-1:0]      cur_idx_q;
    logic [IW-1:0]      last_idx_q;
    logic [BW-1:0]      beat_cnt_q;
    logic [BW-1:0]      beat_cnt_d;
    logic               busy_q;

    logic               in_burst;
    logic               cur_valid;
    logic               xfer;
    logic [IW-1:0]      pick_idx;
    logic               pick_found;

    rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req_i      (req_valid),
        .last_idx_i (last_idx_q),
        .pick_idx_o (pick_idx),
        .found_o    (pick_found)
    );

    // Reset gates the handshake so a burst dropped by rst never writes in that cycle.
    always_comb begin
        in_burst   = (state_q == BURST);
        cur_valid  = req_valid[cur_idx_q];
        xfer       = in_burst && cur_valid && !fifo_full && !rst;
        beat_cnt_d = beat_cnt_q + 1'b1;
        req_ready  = '0;
        if (in_burst && !fifo_full && !rst) begin
            req_ready[cur_idx_q] = 1'b1;
        end
        fifo_wr_en   = xfer;
        fifo_data_in = in_burst ? req_data[cur_idx_q*DATA_WIDTH +: DATA_WIDTH] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            cur_idx_q  <= '0;
            last_idx_q <= LAST_REQ;
            beat_cnt_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        state_q    <= BURST;
                        grant_q    <= ONE_HOT0 << pick_idx;
                        cur_idx_q  <= pick_idx;
                        last_idx_q <= pick_idx;
                        beat_cnt_q <= '0;
                        busy_q     <= 1'b1;
                    end
                end
                BURST: begin
                    if (!cur_valid) begin
                        state_q <= IDLE;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                    end else if (xfer) begin
                        beat_cnt_q <= beat_cnt_d;
                        if (beat_cnt_d == BURST_LEN) begin
                            state_q <= IDLE;
                            grant_q <= '0;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant = grant_q;
    assign busy  = busy_q;

`ifdef FIFO_WR_ARB_STATS_EN
    logic [STAT_W-1:0]              stall_cnt_q;
    logic [NUM_REQ-1:0][STAT_W-1:0] beat_total_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            beat_total_q <= '0;
        end else begin
            if (in_burst && cur_valid && fifo_full && stall_cnt_q != '1) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (xfer && beat_total_q[cur_idx_q] != '1) begin
                beat_total_q[cur_idx_q] <= beat_total_q[cur_idx_q] + 1'b1;
            end
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign beat_total = beat_total_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed bench with per-cycle behavioural model and depth-16 FIFO stand-in
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int MB = 4;
    localparam int DEPTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [NR-1:0]    req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_ready;
    logic             fifo_wr_en;
    logic [DW-1:0]    fifo_data_in;
    logic             fifo_full;
    logic [NR-1:0]    grant;
    logic             busy;
`ifdef FIFO_WR_ARB_STATS_EN
    logic [31:0]      stall_cnt;
    logic [NR*32-1:0] beat_total;
`endif

    fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_data_in (fifo_data_in),
        .fifo_full    (fifo_full),
        .grant        (grant),
        .busy         (busy)
`ifdef FIFO_WR_ARB_STATS_EN
        ,
        .stall_cnt    (stall_cnt),
        .beat_total   (beat_total)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    logic [31:0] src_base [NR] = '{default: 0};
    int          src_cnt  [NR] = '{default: 0};
    int          src_left [NR] = '{default: 0};

    logic [31:0] fifo_q [$];
    logic [31:0] exp_q [$];

    logic          pend_wr;
    logic [31:0]   pend_data;
    logic [NR-1:0] pend_acc;

    int m_owner = -1;
    int m_last  = NR - 1;
    int m_beats = 0;
    int m_stall = 0;
    int m_tot [NR] = '{default: 0};

    always_comb begin
        for (int i = 0; i < NR; i++) begin
            req_valid[i]        = (src_left[i] > 0);
            req_data[i*DW +: DW] = src_base[i] + 32'(src_cnt[i]);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    // Compare against the model, sample the environment, then advance the model.
    always @(negedge clk) begin
        logic [NR-1:0] e_grant, e_ready;
        logic          e_wr, e_busy;
        logic [DW-1:0] e_data;
        int            pk;
        e_busy  = (m_owner >= 0);
        e_grant = e_busy ? NR'(1 << m_owner) : '0;
        e_ready = (e_busy && !rst && !fifo_full) ? NR'(1 << m_owner) : '0;
        e_wr    = e_busy && !rst && !fifo_full && req_valid[m_owner];
        e_data  = e_busy ? req_data[m_owner*DW +: DW] : '0;
        if (chk_en) begin
            chk("grant", grant, e_grant);
            chk("busy", busy, e_busy);
            chk("req_ready", req_ready, e_ready);
            chk("fifo_wr_en", fifo_wr_en, e_wr);
            chk("fifo_data_in", fifo_data_in, e_data);
`ifdef FIFO_WR_ARB_STATS_EN
            chk("stall_cnt", stall_cnt, m_stall);
            for (int i = 0; i < NR; i++) chk("beat_total", beat_total[i*32 +: 32], m_tot[i]);
`endif
        end
        pend_wr   = fifo_wr_en;
        pend_data = fifo_data_in;
        pend_acc  = req_ready & req_valid;
        if (rst) begin
            m_owner = -1; m_last = NR - 1; m_beats = 0; m_stall = 0;
            for (int i = 0; i < NR; i++) m_tot[i] = 0;
        end else if (m_owner < 0) begin
            pk = -1;
            for (int k = 1; k <= NR; k++)
                if (pk < 0 && req_valid[(m_last + k) % NR]) pk = (m_last + k) % NR;
            if (pk >= 0) begin m_owner = pk; m_last = pk; m_beats = 0; end
        end else begin
            if (req_valid[m_owner] && fifo_full) m_stall++;
            if (!req_valid[m_owner]) m_owner = -1;
            else if (e_wr) begin
                m_tot[m_owner]++;
                m_beats++;
                if (m_beats == MB) m_owner = -1;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (pend_wr === 1'b1) fifo_q.push_back(pend_data);
        for (int i = 0; i < NR; i++)
            if (pend_acc[i] === 1'b1) begin src_cnt[i]++; src_left[i]--; end
        fifo_full = (fifo_q.size() >= DEPTH);
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic set_src(input int i, input logic [31:0] base, input int left);
        src_base[i] = base; src_cnt[i] = 0; src_left[i] = left;
    endtask

    task automatic pop_one();
        void'(fifo_q.pop_front());
        fifo_full = (fifo_q.size() >= DEPTH);
    endtask

    task automatic drain_chk(input string nm);
        logic [31:0] e, g;
        chk({nm, "_level"}, fifo_q.size(), exp_q.size());
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (fifo_q.size() > 0) ? fifo_q.pop_front() : 'x;
            chk(nm, g, e);
        end
        fifo_q.delete();
        fifo_full = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; fifo_full = 1'b0;
        cyc(1);
        chk_en = 1'b1;
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wr_en", fifo_wr_en, 0);
        chk("rst_data", fifo_data_in, 0);
        cyc(1);
        rst = 1'b0;

        // single requester: two bursts separated by one idle cycle
        set_src(2, 32'hA0, 8);
        cyc(1); chk("s1_grant_c1", grant, 4'b0100);
        cyc(4); chk("s1_grant_gap", grant, 4'b0000);
        cyc(1); chk("s1_regrant", grant, 4'b0100);
        cyc(6);
        for (int b = 0; b < 8; b++) exp_q.push_back(32'hA0 + b);
        drain_chk("s1_drain");

        // all four requesting after reset: order 0,1,2,3
        rst = 1'b1; cyc(1);
        chk("rst2_grant", grant, 0);
        chk("rst2_ready", req_ready, 0);
        rst = 1'b0;
        for (int p = 0; p < NR; p++) set_src(p, 32'(p * 16), 4);
        cyc(1);  chk("s2_g0", grant, 4'b0001);
        cyc(5);  chk("s2_g1", grant, 4'b0010);
        cyc(5);  chk("s2_g2", grant, 4'b0100);
        cyc(5);  chk("s2_g3", grant, 4'b1000);
        cyc(5);  chk("s2_idle", grant, 4'b0000);
        for (int p = 0; p < NR; p++)
            for (int b = 0; b < 4; b++) exp_q.push_back(32'(p * 16 + b));
        drain_chk("s2_drain");

        // FIFO fills during port 1's burst
        for (int b = 0; b < 10; b++) fifo_q.push_back(32'hF0 + b);
        set_src(0, 32'h00, 4); set_src(1, 32'h10, 4);
        cyc(1); chk("s3_g0", grant, 4'b0001);
        cyc(7);
        chk("s3_full_wr", fifo_wr_en, 0);
        chk("s3_full_grant", grant, 4'b0010);
        chk("s3_full_ready", req_ready, 0);
        cyc(2); pop_one(); #1;
        chk("s3_unstall_wr", fifo_wr_en, 1);
        chk("s3_unstall_data", fifo_data_in, 32'h12);
        cyc(1); pop_one(); #1;
        chk("s3_last_data", fifo_data_in, 32'h13);
        cyc(1); chk("s3_release", grant, 4'b0000);
`ifdef FIFO_WR_ARB_STATS_EN
        chk("s3_stall_cnt", stall_cnt, 2);
        chk("s3_beats0", beat_total[0 +: 32], 8);
        chk("s3_beats1", beat_total[32 +: 32], 8);
        chk("s3_beats3", beat_total[96 +: 32], 4);
`endif
        for (int b = 2; b < 10; b++) exp_q.push_back(32'hF0 + b);
        for (int b = 0; b < 4; b++) exp_q.push_back(32'h00 + b);
        for (int b = 0; b < 4; b++) exp_q.push_back(32'h10 + b);
        drain_chk("s3_drain");

        // port 2 drops valid after 2 beats
        set_src(2, 32'h20, 2); set_src(3, 32'h30, 4);
        cyc(1); chk("s4_g2", grant, 4'b0100);
        cyc(2); chk("s4_drop_wr", fifo_wr_en, 0);
        cyc(1); chk("s4_idle", grant, 4'b0000);
        cyc(1); chk("s4_g3", grant, 4'b1000);
        cyc(6);
        exp_q.push_back(32'h20); exp_q.push_back(32'h21);
        for (int b = 0; b < 4; b++) exp_q.push_back(32'h30 + b);
        drain_chk("s4_drain");

        // reset during the third beat
        set_src(2, 32'h60, 8);
        cyc(1); chk("s5_g2", grant, 4'b0100);
        cyc(2);
        rst = 1'b1;
        set_src(1, 32'h70, 4); set_src(3, 32'h80, 4);
        #1;
        chk("s5_rst_wr", fifo_wr_en, 0);
        chk("s5_rst_ready", req_ready, 0);
        cyc(1);
        rst = 1'b0;
        chk("s5_post_grant", grant, 0);
        chk("s5_post_busy", busy, 0);
        chk("s5_post_ready", req_ready, 0);
        cyc(1); chk("s5_regrant", grant, 4'b0010);
        cyc(25);
`ifdef FIFO_WR_ARB_STATS_EN
        chk("s5_beats2", beat_total[64 +: 32], 6);
`endif
        exp_q.push_back(32'h60); exp_q.push_back(32'h61);
        for (int b = 0; b < 4; b++) exp_q.push_back(32'h70 + b);
        for (int b = 2; b < 6; b++) exp_q.push_back(32'h60 + b);
        for (int b = 0; b < 4; b++) exp_q.push_back(32'h80 + b);
        exp_q.push_back(32'h66); exp_q.push_back(32'h67);
        drain_chk("s5_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
